// File: rtl/remove_v_border_if.sv
// FIFO port bundles for remove_v_border: a multi-flux first-word-fall-through
// read side (one shared head, per-flux empty/read) and a single write side.
interface fifo_rd_if #(
  parameter int DW   = 8,
  parameter int FLUX = 2
);
  logic [DW-1:0]   dout;
  logic [FLUX-1:0] empty;
  logic [FLUX-1:0] read;

  modport master (input dout, input empty, output read);
  modport slave  (output dout, output empty, input read);
endinterface

interface fifo_wr_if #(
  parameter int DW = 8
);
  logic [DW-1:0] din;
  logic          write;
  logic          full;

  modport master (output din, output write, input full);
  modport slave  (input din, input write, output full);
endinterface

// File: rtl/remove_v_border.sv
// Vertical border removal for the tagged multi-flux HEVC interpolation path.
// Optional RVB_BOTTOM_DROP_EN: also drop the 4 bottom rows (blocks of E+7 rows).
module remove_v_border #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 18,
  parameter int EXT_WIDTH  = 7
) (
  input  logic       clk,
  input  logic       rst,
  fifo_rd_if.master  read_port_A,
  fifo_rd_if.master  read_port_ext_size,
  fifo_wr_if.master  write_port
);

  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH;
  localparam int ROW_WIDTH = EXT_WIDTH + 1;

  localparam logic [ROW_WIDTH-1:0] TOP_LAST = ROW_WIDTH'(2);
`ifdef RVB_BOTTOM_DROP_EN
  localparam logic [ROW_WIDTH-1:0] BOT_LAST = ROW_WIDTH'(3);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_TOP,
`ifdef RVB_BOTTOM_DROP_EN
    S_PASS,
    S_BOT
`else
    S_PASS
`endif
  } state_t;

  state_t               state_q [FLUX];
  state_t               state_d [FLUX];
  logic [EXT_WIDTH-1:0] size_q  [FLUX];
  logic [EXT_WIDTH-1:0] size_d  [FLUX];
  logic [EXT_WIDTH-1:0] col_q   [FLUX];
  logic [EXT_WIDTH-1:0] col_d   [FLUX];
  logic [ROW_WIDTH-1:0] row_q   [FLUX];
  logic [ROW_WIDTH-1:0] row_d   [FLUX];

  logic [FLUX-1:0]      fire;
  logic                 found;
  logic [TAG_WIDTH-1:0] win;
  logic [EXT_WIDTH-1:0] size_m1;
  logic                 last_col;
  logic [EXT_WIDTH-1:0] col_inc;

  logic [FLUX-1:0]      rd_a;
  logic [FLUX-1:0]      rd_ext;
  logic                 wr;
  logic [WIDTH-1:0]     din;

  // Tag bits of the incoming words carry no information for this stage.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{read_port_A.dout[WIDTH-1:DATA_WIDTH],
                             read_port_ext_size.dout[EXT_WIDTH+TAG_WIDTH-1:EXT_WIDTH]};

  // NOTE: per-flux state lives in flops, not RAM, so clearing every entry
  // in the reset branch is legal and gives every flux a clean IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FLUX; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        state_q[i] <= S_IDLE;
        size_q[i]  <= '0;
        col_q[i]   <= '0;
        row_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d  = state_q;
    size_d   = size_q;
    col_d    = col_q;
    row_d    = row_q;
    rd_a     = '0;
    rd_ext   = '0;
    wr       = 1'b0;
    din      = '0;
    fire     = '0;
    found    = 1'b0;
    win      = '0;
    size_m1  = '0;
    last_col = 1'b0;
    col_inc  = '0;

    for (int i = 0; i < FLUX; i++) begin
      case (state_q[i])
        S_IDLE:  fire[i] = !read_port_ext_size.empty[i];
        S_PASS:  fire[i] = !read_port_A.empty[i] && !write_port.full;
        default: fire[i] = !read_port_A.empty[i];
      endcase
    end

    // Lowest-index fireable flux wins.
    for (int i = 0; i < FLUX; i++) begin
      if (fire[i] && !found) begin
        found = 1'b1;
        win   = TAG_WIDTH'(i);
      end
    end

    if (found && !rst) begin
      size_m1  = size_q[win] - EXT_WIDTH'(1);
      last_col = (col_q[win] == size_m1);
      col_inc  = last_col ? '0 : col_q[win] + EXT_WIDTH'(1);

      case (state_q[win])
        S_IDLE: begin
          rd_ext[win]  = 1'b1;
          size_d[win]  = read_port_ext_size.dout[EXT_WIDTH-1:0];
          col_d[win]   = '0;
          row_d[win]   = '0;
          state_d[win] = S_TOP;
        end
        S_TOP: begin
          rd_a[win]  = 1'b1;
          col_d[win] = col_inc;
          if (last_col) begin
            if (row_q[win] == TOP_LAST) begin
              row_d[win]   = '0;
              state_d[win] = S_PASS;
            end else begin
              row_d[win] = row_q[win] + ROW_WIDTH'(1);
            end
          end
        end
        S_PASS: begin
          rd_a[win]  = 1'b1;
          wr         = 1'b1;
          din        = {win, read_port_A.dout[DATA_WIDTH-1:0]};
          col_d[win] = col_inc;
          if (last_col) begin
            if (row_q[win] == {1'b0, size_m1}) begin
              row_d[win] = '0;
`ifdef RVB_BOTTOM_DROP_EN
              state_d[win] = S_BOT;
`else
              state_d[win] = S_IDLE;
`endif
            end else begin
              row_d[win] = row_q[win] + ROW_WIDTH'(1);
            end
          end
        end
`ifdef RVB_BOTTOM_DROP_EN
        S_BOT: begin
          rd_a[win]  = 1'b1;
          col_d[win] = col_inc;
          if (last_col) begin
            if (row_q[win] == BOT_LAST) begin
              row_d[win]   = '0;
              state_d[win] = S_IDLE;
            end else begin
              row_d[win] = row_q[win] + ROW_WIDTH'(1);
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign read_port_A.read        = rd_a;
  assign read_port_ext_size.read = rd_ext;
  assign write_port.write        = wr;
  assign write_port.din          = din;

endmodule

// File: tb/tb_remove_v_border.sv
// Scoreboard bench for remove_v_border: queue-modelled FIFOs, per-flux expected
// queues filled at stimulus time, and a negedge monitor that pops and compares.
module tb_remove_v_border;

  localparam int FLUX       = 2;
  localparam int DATA_WIDTH = 18;
  localparam int EXT_WIDTH  = 7;
  localparam int TAG_WIDTH  = 1;
  localparam int WIDTH      = DATA_WIDTH + TAG_WIDTH;
`ifdef RVB_BOTTOM_DROP_EN
  localparam int BOT_ROWS = 4;
`else
  localparam int BOT_ROWS = 0;
`endif

  typedef logic [DATA_WIDTH-1:0] sample_t;

  logic clk;
  logic rst;

  fifo_rd_if #(.DW(WIDTH), .FLUX(FLUX))               a_if ();
  fifo_rd_if #(.DW(EXT_WIDTH + TAG_WIDTH), .FLUX(FLUX)) ext_if ();
  fifo_wr_if #(.DW(WIDTH))                            wr_if ();

  remove_v_border #(
    .FLUX(FLUX),
    .DATA_WIDTH(DATA_WIDTH),
    .EXT_WIDTH(EXT_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .read_port_A(a_if),
    .read_port_ext_size(ext_if),
    .write_port(wr_if)
  );

  sample_t                      a_q   [FLUX][$];
  logic [EXT_WIDTH-1:0]         ext_q [FLUX][$];
  logic [WIDTH-1:0]             exp_q [FLUX][$];
  logic [WIDTH-1:0]             head_a   [FLUX];
  logic [EXT_WIDTH+TAG_WIDTH-1:0] head_ext [FLUX];
  logic rst_r;
  logic full_r;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int writes = 0;
  int a_pops [FLUX];
  int ext_pops [FLUX];
  int first_pop_cyc [FLUX];
  int last_pop_cyc [FLUX];
  int mark_cyc = -1;
  sample_t mark_val = '1;
  int ext_cyc_q [$];

  // The shared FWFT head shows the word of whichever flux is being popped.
  assign a_if.dout   = a_if.read[1]   ? head_a[1]   : head_a[0];
  assign ext_if.dout = ext_if.read[1] ? head_ext[1] : head_ext[0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rows_of(input int e);
    return e + 3 + BOT_ROWS;
  endfunction

  function automatic bit busy();
    for (int f = 0; f < FLUX; f++)
      if (a_q[f].size() != 0 || ext_q[f].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Push samples lo..hi-1 of an E-sized block; interior rows 3..3+E-1 are expected.
  task automatic push_samples(input int f, input int e, input int base, input int lo, input int hi);
    if (lo == 0) ext_q[f].push_back(EXT_WIDTH'(e));
    for (int k = lo; k < hi; k++) begin
      a_q[f].push_back(sample_t'(base + k));
      if (k >= 3 * e && k < 3 * e + e * e)
        exp_q[f].push_back({TAG_WIDTH'(f), sample_t'(base + k)});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (busy() && n < 20000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, " drained"}, 64'(busy()), 64'(0));
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO model: inputs change only just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rst = rst_r;
      wr_if.full = full_r;
      for (int f = 0; f < FLUX; f++) begin
        a_if.empty[f]   = (a_q[f].size() == 0);
        ext_if.empty[f] = (ext_q[f].size() == 0);
        head_a[f]   = (a_q[f].size() != 0)   ? {~TAG_WIDTH'(f), a_q[f][0]}   : '0;
        head_ext[f] = (ext_q[f].size() != 0) ? {~TAG_WIDTH'(f), ext_q[f][0]} : '0;
      end
    end
  end

  // Monitor: pops model FIFOs and scoreboards writes at the inactive edge.
  initial begin
    sample_t v;
    int t;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check("reset read_A", 64'(a_if.read), 64'(0));
        check("reset read_ext", 64'(ext_if.read), 64'(0));
        check("reset write", 64'(wr_if.write), 64'(0));
      end
      check("single action", 64'(($countones(a_if.read) + $countones(ext_if.read)) <= 1), 64'(1));
      if (!wr_if.write) check("din without write", 64'(wr_if.din), 64'(0));
      for (int f = 0; f < FLUX; f++) begin
        if (ext_if.read[f]) begin
          if (ext_q[f].size() == 0) check("ext pop on empty", 64'(ext_q[f].size()), 64'(1));
          else begin
            void'(ext_q[f].pop_front());
            ext_pops[f]++;
            if (f == 0) ext_cyc_q.push_back(cyc);
          end
        end
        if (a_if.read[f]) begin
          if (a_q[f].size() == 0) check("A pop on empty", 64'(a_q[f].size()), 64'(1));
          else begin
            v = a_q[f].pop_front();
            a_pops[f]++;
            if (first_pop_cyc[f] < 0) first_pop_cyc[f] = cyc;
            last_pop_cyc[f] = cyc;
            if (f == 0 && v == mark_val) mark_cyc = cyc;
          end
        end
      end
      if (wr_if.write) begin
        writes++;
        t = int'(wr_if.din[WIDTH-1 -: TAG_WIDTH]);
        if (exp_q[t].size() == 0) check("spurious write", 64'(exp_q[t].size()), 64'(1));
        else check("write data", 64'(wr_if.din), 64'(exp_q[t].pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int w0, p0, p1, e1;
    rst = 1'b1;
    rst_r = 1'b1;
    full_r = 1'b0;
    wr_if.full = 1'b0;
    a_if.empty = '1;
    ext_if.empty = '1;
    for (int f = 0; f < FLUX; f++) begin
      head_a[f] = '0;
      head_ext[f] = '0;
      a_pops[f] = 0;
      ext_pops[f] = 0;
      first_pop_cyc[f] = -1;
      last_pop_cyc[f] = -1;
    end
    repeat (4) step();
    rst_r = 1'b0;
    step();

    // Flux 0: E=4 block, then an E=1 block queued right behind it.
    mark_val = sample_t'(4 * rows_of(4) - 1);
    ext_cyc_q.delete();
    w0 = writes;
    p0 = a_pops[0];
    push_samples(0, 4, 0, 0, 4 * rows_of(4));
    push_samples(0, 1, 100, 0, rows_of(1));
    drain("t1");
    check("t1 writes", 64'(writes - w0), 64'(17));
    check("t1 A pops", 64'(a_pops[0] - p0), 64'(4 * rows_of(4) + rows_of(1)));
    check("t1 ext pops", 64'(ext_cyc_q.size()), 64'(2));
    if (ext_cyc_q.size() >= 2)
      check("t1 next ext pop cycle", 64'(ext_cyc_q[1]), 64'(mark_cyc + 1));
    check("t1 flux0 done", 64'(exp_q[0].size()), 64'(0));

    // Both fluxes E=2, loaded together: flux 0 drains completely first.
    step();
    for (int f = 0; f < FLUX; f++) begin
      first_pop_cyc[f] = -1;
      last_pop_cyc[f] = -1;
    end
    w0 = writes;
    push_samples(0, 2, 200, 0, 2 * rows_of(2));
    push_samples(1, 2, 300, 0, 2 * rows_of(2));
    drain("t2");
    check("t2 writes", 64'(writes - w0), 64'(8));
    check("t2 flux1 after flux0", 64'(first_pop_cyc[1] > last_pop_cyc[0]), 64'(1));
    check("t2 flux0 done", 64'(exp_q[0].size()), 64'(0));
    check("t2 flux1 done", 64'(exp_q[1].size()), 64'(0));

    // Flux 0 parked in PASS; full stalls it while flux 1 runs its TOP rows.
    step();
    w0 = writes;
    push_samples(0, 4, 400, 0, 13);
    drain("t3 pre");
    step();
    full_r = 1'b1;
    p0 = a_pops[0];
    p1 = a_pops[1];
    e1 = ext_pops[1];
    push_samples(1, 4, 500, 0, 4 * rows_of(4));
    push_samples(0, 4, 400, 13, 4 * rows_of(4));
    repeat (6) step();
    full_r = 1'b0;
    @(negedge clk);
    #1;
    check("t3 flux0 stalled", 64'(a_pops[0] - p0), 64'(0));
    check("t3 flux1 top pops", 64'(a_pops[1] - p1), 64'(5));
    check("t3 flux1 ext pop", 64'(ext_pops[1] - e1), 64'(1));
    drain("t3");
    check("t3 writes", 64'(writes - w0), 64'(32));
    check("t3 flux0 done", 64'(exp_q[0].size()), 64'(0));
    check("t3 flux1 done", 64'(exp_q[1].size()), 64'(0));

    // Largest block.
    step();
    w0 = writes;
    p0 = a_pops[0];
    push_samples(0, 64, 0, 0, 64 * rows_of(64));
    drain("t4");
    check("t4 writes", 64'(writes - w0), 64'(4096));
    check("t4 A pops", 64'(a_pops[0] - p0), 64'(64 * rows_of(64)));
    check("t4 flux0 done", 64'(exp_q[0].size()), 64'(0));

    // Reset while flux 0 is in PASS row 1 with data available.
    step();
    push_samples(0, 4, 600, 0, 18);
    drain("t5 pre");
    check("t5 pre writes", 64'(exp_q[0].size()), 64'(0));
    step();
    a_q[0].push_back(sample_t'(618));
    a_q[0].push_back(sample_t'(619));
    rst_r = 1'b1;
    p0 = a_pops[0];
    w0 = writes;
    step();
    rst_r = 1'b0;
    a_q[0].delete();
    @(negedge clk);
    #1;
    check("t5 no pop in reset", 64'(a_pops[0] - p0), 64'(0));
    check("t5 no write in reset", 64'(writes - w0), 64'(0));
    step();
    w0 = writes;
    push_samples(0, 1, 700, 0, rows_of(1));
    drain("t5");
    check("t5 writes", 64'(writes - w0), 64'(1));
    check("t5 flux0 done", 64'(exp_q[0].size()), 64'(0));

    repeat (3) step();
    check("final flux0 empty", 64'(exp_q[0].size()), 64'(0));
    check("final flux1 empty", 64'(exp_q[1].size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
